// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - multicycle 32x32 shift-and-add multiply sequencer driving a shared adder
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEG_A  = 3'd1;
  localparam logic [2:0] S_NEG_B  = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_NEG_LO = 3'd4;
  localparam logic [2:0] S_NEG_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic             z_q, z_d;
  logic             carry;

  // The shared adder has no carry-out, so rebuild it from the operand and sum MSBs.
  assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1])
               | ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      S_NEG_A: begin
        add_a = m_q[WIDTH-1] ? ~m_q : m_q;
        add_b = m_q[WIDTH-1] ? ONE : '0;
      end
      S_NEG_B: begin
        add_a = lo_q[WIDTH-1] ? ~lo_q : lo_q;
        add_b = lo_q[WIDTH-1] ? ONE : '0;
      end
      S_MUL: begin
        add_a = hi_q;
        add_b = lo_q[0] ? m_q : '0;
      end
      S_NEG_LO: begin
        add_a = neg_q ? ~lo_q : lo_q;
        add_b = neg_q ? ONE : '0;
      end
      S_NEG_HI: begin
        if (neg_q) begin
          add_a = ~hi_q;
          add_b = {{(WIDTH-1){1'b0}}, z_q};
        end
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn_d   = signed_op;
          z_d     = 1'b0;
          state_d = signed_op ? S_NEG_A : S_MUL;
        end
      end
      S_NEG_A: begin
        m_d     = add_sum;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        lo_d    = add_sum;
        state_d = S_MUL;
      end
      S_MUL: begin
        hi_d  = {carry, add_sum[WIDTH-1:1]};
        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = sgn_q ? S_NEG_LO : S_DONE;
      end
      S_NEG_LO: begin
        // Two's-complement of the 64-bit magnitude: the low word carries into hi only when it was zero.
        if (neg_q) begin
          lo_d = add_sum;
          z_d  = (lo_q == '0);
        end else begin
          z_d  = 1'b0;
        end
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (neg_q) hi_d = add_sum;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      z_q     <= z_d;
    end
  end

endmodule
